// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with per-register pending (scoreboard) bits.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_2w2r #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              pend0,
    output logic              pend1,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              rsv_ok;

    logic [ADDR_W-1:0] ra    [2];
    logic [DATA_W-1:0] rd_v  [2];
    logic              pd_v  [2];

    assign wr0_ok = we0    && !((ZERO_R0 != 0) && (wa0 == '0));
    assign wr1_ok = we1    && !((ZERO_R0 != 0) && (wa1 == '0));
    assign rsv_ok = rsv_en && !((ZERO_R0 != 0) && (rsv_addr == '0));

    // Reserve is applied last so it wins over a same-cycle clearing write.
    always_comb begin
        pend_nxt = pend;
        if (wr0_ok) pend_nxt[wa0] = 1'b0;
        if (wr1_ok) pend_nxt[wa1] = 1'b0;
        if (rsv_ok) pend_nxt[rsv_addr] = 1'b1;
        cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr0_ok) regs[wa0] <= wd0;
            // Port 1 is assigned second so it wins an address conflict.
            if (wr1_ok) regs[wa1] <= wd1;
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    assign ra[0] = ra0;
    assign ra[1] = ra1;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd_v[p] = regs[ra[p]];
            pd_v[p] = pend[ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (we0 && (wa0 == ra[p])) begin
                rd_v[p] = wd0;
                pd_v[p] = rsv_en && (rsv_addr == ra[p]);
            end
            if (we1 && (wa1 == ra[p])) begin
                rd_v[p] = wd1;
                pd_v[p] = rsv_en && (rsv_addr == ra[p]);
            end
`endif
            if (rst || ((ZERO_R0 != 0) && (ra[p] == '0))) begin
                rd_v[p] = '0;
                pd_v[p] = 1'b0;
            end
        end
    end

    assign rd0   = rd_v[0];
    assign rd1   = rd_v[1];
    assign pend0 = pd_v[0];
    assign pend1 = pd_v[1];

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed self-checking bench for regfile_2w2r; one default instance and one
// with the hard-wired zero register, both driven by the same stimulus.
module tb_regfile_2w2r;

    logic       clk = 1'b0;
    logic       rst;
    logic       we0, we1, rsv_en;
    logic [2:0] wa0, wa1, rsv_addr, ra0, ra1;
    logic [7:0] wd0, wd1;

    logic [7:0] rd0, rd1, zrd0, zrd1;
    logic       pend0, pend1, zpend0, zpend1;
    logic [3:0] pend_cnt, zpend_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_2w2r #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .ra0(ra0), .ra1(ra1),
        .rd0(rd0), .rd1(rd1),
        .pend0(pend0), .pend1(pend1),
        .pend_cnt(pend_cnt)
    );

    regfile_2w2r #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .ra0(ra0), .ra1(ra1),
        .rd0(zrd0), .rd1(zrd1),
        .pend0(zpend0), .pend1(zpend1),
        .pend_cnt(zpend_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rsv_en = 0;
        wa0 = 0; wa1 = 0; rsv_addr = 0;
        wd0 = 0; wd1 = 0;
    endtask

    initial begin
        logic [7:0] exp_pre;
        idle();
        ra0 = 0; ra1 = 0;
        rst = 1;
        step(); step();
        rst = 0;
        #1;
        check("reset_rd0", rd0, 0);
        check("reset_rd1", rd1, 0);
        check("reset_pend0", pend0, 0);
        check("reset_pend1", pend1, 0);
        check("reset_cnt", pend_cnt, 0);

        // Fill every register with FF while reserving it: all 8 pending.
        for (int i = 0; i < 8; i++) begin
            we0 = 1; wa0 = 3'(i); wd0 = 8'hFF;
            rsv_en = 1; rsv_addr = 3'(i);
            step();
        end
        idle();
        ra0 = 7; ra1 = 0;
        #1;
        check("fill_rd0_r7", rd0, 8'hFF);
        check("fill_pend0_r7", pend0, 1);
        check("fill_cnt_full", pend_cnt, 8);
        check("zfill_cnt", zpend_cnt, 7);
        check("zfill_rd_r0", zrd1, 0);

        // Reset overrides a same-cycle write/reserve and masks bypass paths.
        rst = 1;
        we0 = 1; wa0 = 2; wd0 = 8'h55; rsv_en = 1; rsv_addr = 2;
        ra0 = 2; ra1 = 7;
        #1;
        check("rst_forced_rd0", rd0, 0);
        check("rst_forced_rd1", rd1, 0);
        check("rst_forced_pend1", pend1, 0);
        step();
        rst = 0;
        idle();
        for (int i = 0; i < 8; i++) begin
            ra0 = 3'(i); ra1 = 3'(7 - i);
            #1;
            check($sformatf("clr_rd0_r%0d", i), rd0, 0);
            check($sformatf("clr_rd1_r%0d", 7 - i), rd1, 0);
            check($sformatf("clr_pend0_r%0d", i), pend0, 0);
        end
        check("clr_cnt", pend_cnt, 0);
        check("zclr_cnt", zpend_cnt, 0);

        // Dual write to distinct addresses.
        we0 = 1; wa0 = 2; wd0 = 8'd42;
        we1 = 1; wa1 = 4; wd1 = 8'd100;
        ra0 = 2; ra1 = 4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("dual_pre_rd0", rd0, 8'd42);
        check("dual_pre_rd1", rd1, 8'd100);
`else
        check("dual_pre_rd0", rd0, 0);
        check("dual_pre_rd1", rd1, 0);
`endif
        step();
        idle();
        #1;
        check("dual_rd0", rd0, 8'd42);
        check("dual_rd1", rd1, 8'd100);

        // Same-address conflict: port 1 wins.
        we0 = 1; wa0 = 3; wd0 = 8'h11;
        we1 = 1; wa1 = 3; wd1 = 8'h22;
        ra0 = 3; ra1 = 2;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 8'h22;
`else
        exp_pre = 8'h00;
`endif
        check("conf_pre_rd0", rd0, exp_pre);
        step();
        idle();
        #1;
        check("conf_rd0", rd0, 8'h22);
        check("conf_rd1_other", rd1, 8'd42);

        // Scoreboard.
        rsv_en = 1; rsv_addr = 5;
        step();
        rsv_addr = 6;
        step();
        idle();
        ra0 = 5; ra1 = 6;
        #1;
        check("sb_cnt2", pend_cnt, 2);
        check("sb_pend_r5", pend0, 1);
        check("sb_pend_r6", pend1, 1);
        we0 = 1; wa0 = 5; wd0 = 8'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("sb_wr_pre_pend0", pend0, 0);
`else
        check("sb_wr_pre_pend0", pend0, 1);
`endif
        step();
        idle();
        #1;
        check("sb_cnt_after_wr", pend_cnt, 1);
        check("sb_pend_r5_clr", pend0, 0);
        check("sb_rd_r5", rd0, 8'd7);
        we1 = 1; wa1 = 6; wd1 = 8'h33; rsv_en = 1; rsv_addr = 6;
        #1;
        check("sb_rsvwr_pre_pend1", pend1, 1);
        step();
        idle();
        #1;
        check("sb_rsvwr_pend1", pend1, 1);
        check("sb_rsvwr_cnt", pend_cnt, 1);
        check("sb_rsvwr_rd1", rd1, 8'h33);
        rsv_en = 1; rsv_addr = 6;
        step();
        idle();
        #1;
        check("sb_rerSV_cnt", pend_cnt, 1);

        // Write R1 while reading it in the same cycle.
        we0 = 1; wa0 = 1; wd0 = 8'd9;
        ra0 = 1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_pre_rd0", rd0, 8'd9);
`else
        check("byp_pre_rd0", rd0, 0);
`endif
        step();
        idle();
        #1;
        check("byp_post_rd0", rd0, 8'd9);

        // Register 0: discarded in the zero instance, ordinary in the other.
        we0 = 1; wa0 = 0; wd0 = 8'hAB; rsv_en = 1; rsv_addr = 0;
        ra0 = 0; ra1 = 0;
        #1;
        check("zero_pre_rd0", zrd0, 0);
        check("zero_pre_pend0", zpend0, 0);
        check("zero_pre_cnt", zpend_cnt, 1);
        step();
        idle();
        #1;
        check("zero_rd0", zrd0, 0);
        check("zero_rd1", zrd1, 0);
        check("zero_pend0", zpend0, 0);
        check("zero_cnt", zpend_cnt, 1);
        check("nz_rd0_r0", rd0, 8'hAB);
        check("nz_pend0_r0", pend0, 1);
        check("nz_cnt", pend_cnt, 2);
        ra0 = 6;
        #1;
        check("zero_inst_rd_r6", zrd0, 8'h33);
        check("zero_inst_pend_r6", zpend0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2w2r.md
# regfile_2w2r

Parametrised multi-port register file, the next generation of the CPU's 8×8 single-write register file. It has two write ports with fixed priority and two asynchronous read ports. It adds synchronous clear on reset, an optional hard-wired zero register and a per-register pending (scoreboard) bit. The datapath uses it for operand fetch and writeback; the issue logic uses the pending bits to stall on outstanding results.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; depth = 2**ADDR_W
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes and reservations

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- rsv_en  in  1  mark register rsv_addr pending
- rsv_addr  in  ADDR_W  register to reserve
- ra0  in  ADDR_W  read address, port 0
- ra1  in  ADDR_W  read address, port 1
- rd0  out  DATA_W  read data, port 0
- rd1  out  DATA_W  read data, port 1
- pend0  out  1  pending bit of ra0
- pend1  out  1  pending bit of ra1
- pend_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: 2**ADDR_W × DATA_W registers and 2**ADDR_W pending bits.
- Write: on a clock edge with weN=1, storage[waN] <= wdN.
- Write conflict: if we0 and we1 both target the same address, port 1's data is stored and port 0 is dropped. Writes to different addresses both commit.
- Pending clear: any committed write to address A clears pend[A].
- Pending set: rsv_en=1 sets pend[rsv_addr].
- Reserve and write to the same address in the same cycle: reserve wins and the bit ends set, because a new producer has been issued. The write data still commits.
- Reserve on an already-pending register: the bit stays set and pend_cnt is unchanged.
- ZERO_R0=1: register 0 reads 0 and pend[0] reads 0. Writes and reservations to address 0 are discarded and never counted.
- Reads: combinational from storage, with no read-port enable.
- pend_cnt: registered population count of the pending bits. It is updated in the same edge as the bits and never exceeds 2**ADDR_W.
- Reset: rst=1 at an edge clears all storage, all pending bits and pend_cnt to 0. Reset overrides any write or reserve in that cycle.

## Timing
- Reset values: rd0=rd1=0, pend0=pend1=0, pend_cnt=0. While rst is high, rd0/rd1/pend0/pend1 are forced to 0 combinationally, including bypass paths.
- Write-to-storage latency: 1 cycle (the edge after the write is presented).
- Read latency: 0 cycles (combinational from ra to rd).
- Without bypass: a read of an address written in the same cycle returns the old value; the new value is visible after the edge.
- Reset mid-operation: a pending reservation or in-flight write in the reset cycle is lost. The first post-reset cycle behaves as after power-on.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: write-through bypass. If raN matches a same-cycle enabled write address, rdN returns that write's data (wd1 if both ports match). pendN then reads 0 unless rsv_en targets the same address that cycle.
- Undefined: no bypass. rdN and pendN reflect registered state only.
- ZERO_R0 masking applies on top of bypass in both builds.

## Test plan
- Reset clear: write 8'hFF to all 8 registers, assert rst for 1 cycle. Then rd0/rd1=0 for every address and pend_cnt=0.
- Dual write: we0 writes R2=42 and we1 writes R4=100 in the same cycle. Next cycle ra0=2, ra1=4 gives rd0=42, rd1=100.
- Conflict: we0 writes R3=8'h11 and we1 writes R3=8'h22 together. Next cycle rd(R3)=8'h22.
- Scoreboard: reserve R5, then R6 on consecutive cycles, giving pend_cnt=2. Write R5=7, giving pend_cnt=1 and pend(R5)=0. Reserve and write R6 in the same cycle, giving pend(R6)=1 and pend_cnt=1.
- Bypass: write R1=9 with ra0=1 in the same cycle. With REGFILE_BYPASS_EN, rd0=9 in that cycle. Without it, rd0 shows the old value and shows 9 after the edge.
- Zero register (ZERO_R0=1): write R0=8'hAB and reserve R0. rd(R0)=0, pend(R0)=0 and pend_cnt is unchanged.
